// File: rtl/controlador_elevador_if.sv
// rtl/controlador_elevador_if.sv - call request and car status bundle for the elevator controller
interface controlador_elevador_if #(
    parameter int FLOORS  = 4,
    parameter int FLOOR_W = $clog2(FLOORS)
);
    logic [FLOORS-1:0]  call_req;
    logic [FLOOR_W-1:0] floor_out;
    logic               dir_up;
    logic               moving;
    logic               door_open;
    logic               arrive;
    logic [FLOORS-1:0]  pending;

    modport master (
        output call_req,
        input  floor_out, dir_up, moving, door_open, arrive, pending
    );

    modport slave (
        input  call_req,
        output floor_out, dir_up, moving, door_open, arrive, pending
    );
endinterface

// File: rtl/controlador_elevador.sv
// rtl/controlador_elevador.sv - SCAN-order elevator controller with travel and door timing
module controlador_elevador #(
    parameter int FLOORS        = 4,
    parameter int FLOOR_W       = $clog2(FLOORS),
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    controlador_elevador_if.slave  bus
);
    localparam int TW = $clog2(TRAVEL_CYCLES + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

    state_t             state_q, state_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;
    logic               dir_q, dir_d;
    logic [TW-1:0]      trav_q, trav_d;
    logic [DW-1:0]      door_q, door_d;
    logic               arrive_q, arrive_d;
    logic [FLOORS-1:0]  pending_q, pending_d;

    logic [FLOORS-1:0]  here, next_here, clr, call_eff;
    logic [FLOOR_W-1:0] next_floor;
    logic               above, below;

    // Any pending call strictly above (up=1) or strictly below (up=0) floor f.
    function automatic logic beyond(input logic [FLOORS-1:0] p,
                                    input logic [FLOOR_W-1:0] f,
                                    input logic up);
        beyond = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (p[i] && (up ? (FLOOR_W'(i) > f) : (FLOOR_W'(i) < f))) beyond = 1'b1;
        end
    endfunction

    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_d      = dir_q;
        trav_d     = trav_q;
        door_d     = door_q;
        arrive_d   = 1'b0;
        clr        = '0;
        call_eff   = bus.call_req;
        here       = FLOORS'(1) << floor_q;
        next_floor = dir_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
        next_here  = FLOORS'(1) << next_floor;
        above      = beyond(pending_q, floor_q, 1'b1);
        below      = beyond(pending_q, floor_q, 1'b0);

        unique case (state_q)
            IDLE: begin
                if (|(pending_q & here)) begin
                    state_d  = DOOR;
                    door_d   = '0;
                    arrive_d = 1'b1;
                    clr      = here;
                end else if (above && (dir_q || !below)) begin
                    dir_d   = 1'b1;
                    state_d = MOVE;
                    trav_d  = '0;
                end else if (below) begin
                    dir_d   = 1'b0;
                    state_d = MOVE;
                    trav_d  = '0;
                end
            end
            MOVE: begin
                if (trav_q == TW'(TRAVEL_CYCLES - 1)) begin
                    floor_d = next_floor;
                    trav_d  = '0;
                    if (|(pending_q & next_here)) begin
                        state_d  = DOOR;
                        door_d   = '0;
                        arrive_d = 1'b1;
                        clr      = next_here;
                    end else if (!beyond(pending_q, next_floor, dir_q)) begin
                        state_d = IDLE;
                    end
                end else begin
                    trav_d = trav_q + TW'(1);
                end
            end
            DOOR: begin
                // A re-call of the open floor only extends the dwell; it is never latched.
                if (|(bus.call_req & here)) begin
                    door_d   = '0;
                    call_eff = bus.call_req & ~here;
                end else if (door_q == DW'(DOOR_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    door_d = door_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        pending_d = (pending_q | call_eff) & ~clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            floor_q   <= '0;
            dir_q     <= 1'b1;
            trav_q    <= '0;
            door_q    <= '0;
            arrive_q  <= 1'b0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_q     <= dir_d;
            trav_q    <= trav_d;
            door_q    <= door_d;
            arrive_q  <= arrive_d;
            pending_q <= pending_d;
        end
    end

    assign bus.floor_out = floor_q;
    assign bus.dir_up    = dir_q;
    assign bus.moving    = (state_q == MOVE);
    assign bus.door_open = (state_q == DOOR);
    assign bus.arrive    = arrive_q;
    assign bus.pending   = pending_q;

    // Direction choices must keep the car inside the shaft.
    a_floor_range: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == MOVE && trav_q == TW'(TRAVEL_CYCLES - 1)) |->
        (dir_q ? (floor_q != FLOOR_W'(FLOORS - 1)) : (floor_q != '0)));
endmodule

// File: tb/tb_controlador_elevador.sv
// tb/tb_controlador_elevador.sv - model-checked directed bench for controlador_elevador
module tb_controlador_elevador;
    localparam int FLOORS = 4;
    localparam int T      = 8;
    localparam int D      = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    controlador_elevador_if #(.FLOORS(FLOORS)) bus ();

    controlador_elevador #(
        .FLOORS(FLOORS), .TRAVEL_CYCLES(T), .DOOR_CYCLES(D)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Behavioural model: mode 0 idle, 1 travelling, 2 door; m_left counts cycles remaining.
    int         m_mode, m_floor, m_left;
    bit         m_dir, m_arrive;
    logic [3:0] m_pend;

    function automatic bit any_dir(input logic [3:0] p, input int f, input bit up);
        any_dir = 0;
        for (int i = 0; i < FLOORS; i++)
            if (p[i] && (up ? i > f : i < f)) any_dir = 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [3:0] old, c;
        if (!rst_n) begin
            m_mode = 0; m_floor = 0; m_left = 0; m_dir = 1; m_arrive = 0; m_pend = 0;
        end else begin
            old = m_pend;
            c = bus.call_req;
            m_arrive = 0;
            case (m_mode)
                0: begin
                    m_pend = old | c;
                    if (old[m_floor]) begin
                        m_mode = 2; m_left = D; m_arrive = 1; m_pend[m_floor] = 0;
                    end else if (any_dir(old, m_floor, 1) && (m_dir || !any_dir(old, m_floor, 0))) begin
                        m_dir = 1; m_mode = 1; m_left = T;
                    end else if (any_dir(old, m_floor, 0)) begin
                        m_dir = 0; m_mode = 1; m_left = T;
                    end
                end
                1: begin
                    m_pend = old | c;
                    m_left--;
                    if (m_left == 0) begin
                        m_floor = m_dir ? m_floor + 1 : m_floor - 1;
                        if (old[m_floor]) begin
                            m_mode = 2; m_left = D; m_arrive = 1; m_pend[m_floor] = 0;
                        end else if (any_dir(old, m_floor, m_dir)) begin
                            m_left = T;
                        end else begin
                            m_mode = 0;
                        end
                    end
                end
                default: begin
                    if (c[m_floor]) begin
                        c[m_floor] = 0; m_left = D;
                    end else begin
                        m_left--;
                        if (m_left == 0) m_mode = 0;
                    end
                    m_pend = old | c;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("cycle", {22'd0, bus.floor_out, bus.dir_up, bus.moving, bus.door_open, bus.arrive, bus.pending},
            {22'd0, 2'(m_floor), m_dir, m_mode == 1, m_mode == 2, m_arrive, m_pend});
    end

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int dc, rises;
        bit mv, pseen, prev;
        bus.call_req = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_floor", bus.floor_out, 0);
        chk("reset_dir", bus.dir_up, 1);
        chk("reset_pending", bus.pending, 0);
        adv(2);
        #2 rst_n = 1'b1;
        adv(1);

        // Single up call to floor 2
        bus.call_req = 4'b0100; adv(1); bus.call_req = '0;
        chk("up_e0_pending", bus.pending, 4'b0100);
        chk("up_e0_moving", bus.moving, 0);
        adv(1);  chk("up_e1_moving", bus.moving, 1);
        adv(8);  chk("up_e9_floor", bus.floor_out, 1);
        adv(8);
        chk("up_e17_state", {bus.floor_out, bus.door_open, bus.arrive, bus.moving, bus.pending}, {2'd2, 3'b110, 4'b0000});
        adv(1);  chk("up_e18_arrive", {bus.arrive, bus.door_open}, 2'b01);
        adv(2);  chk("up_e20_door", bus.door_open, 1);
        adv(1);  chk("up_e21_idle", {bus.door_open, bus.moving}, 2'b00);

        // Current-floor call at floor 2, then re-call on the 3rd door cycle
        bus.call_req = 4'b0100; adv(1); bus.call_req = '0;
        chk("cur2_e0", {bus.pending, bus.door_open}, {4'b0100, 1'b0});
        dc = 0; mv = 0; pseen = 0;
        for (int i = 0; i < 15; i++) begin
            bus.call_req = (i == 3) ? 4'b0100 : 4'b0000;
            adv(1);
            if (bus.door_open) dc++;
            mv |= bus.moving;
            pseen |= bus.pending[2];
        end
        bus.call_req = '0;
        chk("recall_door_len", dc, 7);
        chk("recall_no_move", mv, 0);
        chk("recall_not_latched", pseen, 0);

        // Down to floor 0, then a current-floor call there
        bus.call_req = 4'b0001; adv(1); bus.call_req = '0;
        adv(1);  chk("down_e1", {bus.moving, bus.dir_up}, 2'b10);
        adv(16); chk("down_e17", {bus.floor_out, bus.door_open}, {2'd0, 1'b1});
        adv(4);
        bus.call_req = 4'b0001; adv(1); bus.call_req = '0;
        chk("cur0_e0", {bus.pending, bus.door_open}, {4'b0001, 1'b0});
        adv(1);  chk("cur0_e1", {bus.door_open, bus.moving, bus.arrive}, 3'b101);
        adv(4);  chk("cur0_e5", bus.door_open, 0);

        // Up to floor 1 so the SCAN case starts at floor 1 heading up
        bus.call_req = 4'b0010; adv(1); bus.call_req = '0;
        adv(9);  chk("to1_e9", {bus.floor_out, bus.door_open, bus.dir_up}, {2'd1, 2'b11});
        adv(4);

        // SCAN: calls at 3 and 0 latched together
        bus.call_req = 4'b1001; adv(1); bus.call_req = '0;
        chk("scan_e0_pending", bus.pending, 4'b1001);
        adv(1);  chk("scan_e1", {bus.moving, bus.dir_up}, 2'b11);
        adv(8);  chk("scan_e9", {bus.floor_out, bus.moving}, {2'd2, 1'b1});
        adv(8);  chk("scan_e17", {bus.floor_out, bus.door_open, bus.dir_up, bus.pending}, {2'd3, 2'b11, 4'b0001});
        adv(4);  chk("scan_e21_idle", {bus.floor_out, bus.moving, bus.door_open, bus.dir_up}, {2'd3, 3'b001});
        adv(1);  chk("scan_e22_rev", {bus.moving, bus.dir_up}, 2'b10);
        adv(24); chk("scan_e46", {bus.floor_out, bus.door_open, bus.pending}, {2'd0, 1'b1, 4'b0000});
        adv(4);

        // Call/clear collision on arrival at floor 2
        bus.call_req = 4'b0100; adv(1); bus.call_req = '0;
        adv(16); chk("coll_e16", {bus.floor_out, bus.moving}, {2'd1, 1'b1});
        bus.call_req = 4'b0100; adv(1); bus.call_req = '0;
        chk("coll_e17", {bus.floor_out, bus.door_open, bus.arrive, bus.pending}, {2'd2, 2'b11, 4'b0000});
        rises = 0; mv = 0; prev = 1;
        for (int i = 0; i < 20; i++) begin
            adv(1);
            if (bus.door_open && !prev) rises++;
            prev = bus.door_open;
            mv |= bus.moving;
        end
        chk("coll_no_revisit", {rises[7:0], 7'd0, mv}, 16'd0);
        chk("coll_final", {bus.floor_out, bus.pending}, {2'd2, 4'b0000});

        // Asynchronous reset mid-MOVE at floor 2
        bus.call_req = 4'b1001; adv(1); bus.call_req = '0;
        adv(3);  chk("rst_pre", {bus.floor_out, bus.moving, bus.pending}, {2'd2, 1'b1, 4'b1001});
        #2 rst_n = 1'b0;
        #1 chk("rst_async", {bus.floor_out, bus.dir_up, bus.moving, bus.door_open, bus.arrive, bus.pending},
               {2'd0, 4'b1000, 4'b0000});
        adv(1);
        #2 rst_n = 1'b1;
        adv(3);  chk("rst_after", {bus.floor_out, bus.moving, bus.door_open, bus.pending}, {2'd0, 6'd0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
